// File: rtl/temp_monitor_n.sv
// Per-channel temperature tracker (current/min/max, HOT/NORMAL/COLD with hysteresis) with a serial BCD display converter.
// Flags follow a sample by one cycle; display publishes DATA_W+1 cycles after latching; no backpressure, samples are always accepted.
module temp_monitor_n #(
    parameter int  CHANNELS   = 4,
    parameter int  DATA_W     = 8,
    parameter int  HYST       = 2,
    parameter int  BCD_DIGITS = 3,
    localparam int CW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                    CLOCK_50,
    input  logic                    rst,
    input  logic                    sample_valid,
    input  logic [CW-1:0]           sample_ch,
    input  logic [DATA_W-1:0]       sample_data,
    input  logic [DATA_W-1:0]       thresh_hi,
    input  logic [DATA_W-1:0]       thresh_lo,
    input  logic [CW-1:0]           disp_sel,
    input  logic [1:0]              disp_mode,
    output logic [CHANNELS-1:0]     hot,
    output logic [CHANNELS-1:0]     cold,
    output logic [4*BCD_DIGITS-1:0] disp_bcd,
    output logic                    busy,
    output logic                    disp_valid
);

    function automatic longint pow10(input int n);
        longint r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    generate
        if (pow10(BCD_DIGITS) <= ((longint'(1) << DATA_W) - 1)) begin : g_bcd_too_narrow
            $error("BCD_DIGITS too small to display every DATA_W value");
        end
    endgenerate

    localparam int             BW     = 4 * BCD_DIGITS;
    localparam int             CNT_W  = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);
    localparam logic [CW:0]    CH_LIM = (CW + 1)'(CHANNELS);
    localparam logic [DATA_W:0] HYST_X = (DATA_W + 1)'(HYST);
    localparam logic [DATA_W:0] MAXV   = {1'b0, {DATA_W{1'b1}}};

    typedef enum logic [1:0] {CH_NORMAL, CH_HOT, CH_COLD} ch_state_e;
    typedef enum logic [1:0] {CV_IDLE, CV_CONV, CV_DONE} cv_state_e;

    ch_state_e           chst_q [CHANNELS];
    ch_state_e           chst_d [CHANNELS];
    logic [DATA_W-1:0]   cur_q  [CHANNELS];
    logic [DATA_W-1:0]   cur_d  [CHANNELS];
    logic [DATA_W-1:0]   min_q  [CHANNELS];
    logic [DATA_W-1:0]   min_d  [CHANNELS];
    logic [DATA_W-1:0]   max_q  [CHANNELS];
    logic [DATA_W-1:0]   max_d  [CHANNELS];
    logic [CHANNELS-1:0] seen_q, seen_d;
    logic [CHANNELS-1:0] hot_nxt;

    cv_state_e           cv_q, cv_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   bin_q, bin_d;
    logic [BW-1:0]       bcd_q, bcd_d;
    logic [BW-1:0]       out_q, out_d;
    logic [BW-1:0]       adj;
    logic                dirty_q, dirty_d;
    logic [CW-1:0]       sel_q;
    logic [1:0]          mode_q;

    logic                smp_acc;
    logic                dirty_evt;
    logic [DATA_W-1:0]   hi_m, lo_p;
    logic [DATA_W:0]     lo_sum;
    logic [DATA_W-1:0]   disp_val;
    logic [DATA_W-1:0]   pop;

    function automatic ch_state_e ch_next(input ch_state_e s, input logic [DATA_W-1:0] d,
                                          input logic [DATA_W-1:0] hi, input logic [DATA_W-1:0] lo,
                                          input logic [DATA_W-1:0] him, input logic [DATA_W-1:0] lop);
        ch_state_e n;
        n = s;
        if (d > hi)
            n = CH_HOT;
        else if (d < lo)
            n = CH_COLD;
        else if (s == CH_HOT && d < him)
            n = CH_NORMAL;
        else if (s == CH_COLD && d > lop)
            n = CH_NORMAL;
        return n;
    endfunction

    // Exit thresholds saturate so the hysteresis band never wraps around.
    always_comb begin
        hi_m   = ({1'b0, thresh_hi} >= HYST_X) ? DATA_W'({1'b0, thresh_hi} - HYST_X) : '0;
        lo_sum = {1'b0, thresh_lo} + HYST_X;
        lo_p   = (lo_sum > MAXV) ? MAXV[DATA_W-1:0] : lo_sum[DATA_W-1:0];
    end

    assign smp_acc = sample_valid && ({1'b0, sample_ch} < CH_LIM);

    always_comb begin
        seen_d = seen_q;
        for (int i = 0; i < CHANNELS; i++) begin
            chst_d[i] = chst_q[i];
            cur_d[i]  = cur_q[i];
            min_d[i]  = min_q[i];
            max_d[i]  = max_q[i];
            if (smp_acc && sample_ch == CW'(i)) begin
                cur_d[i]  = sample_data;
                seen_d[i] = 1'b1;
                if (!seen_q[i] || sample_data < min_q[i]) min_d[i] = sample_data;
                if (!seen_q[i] || sample_data > max_q[i]) max_d[i] = sample_data;
                chst_d[i] = ch_next(chst_q[i], sample_data, thresh_hi, thresh_lo, hi_m, lo_p);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            hot[i]     = (chst_q[i] == CH_HOT);
            cold[i]    = (chst_q[i] == CH_COLD);
            hot_nxt[i] = (chst_d[i] == CH_HOT);
        end
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < CHANNELS; i++) pop = pop + {{(DATA_W-1){1'b0}}, hot[i]};
    end

    always_comb begin
        disp_val = '0;
        if (disp_mode == 2'b11)
            disp_val = pop;
        else if ({1'b0, disp_sel} < CH_LIM) begin
            case (disp_mode)
                2'b00:   disp_val = cur_q[disp_sel];
                2'b01:   disp_val = min_q[disp_sel];
                default: disp_val = max_q[disp_sel];
            endcase
        end
    end

    assign dirty_evt = (smp_acc && sample_ch == disp_sel)
                     || (disp_sel != sel_q) || (disp_mode != mode_q)
                     || (disp_mode == 2'b11 && hot_nxt != hot);

    // Add-3 is applied before each shift; the result only reaches disp_bcd on the last step.
    always_comb begin
        for (int d = 0; d < BCD_DIGITS; d++)
            adj[4*d +: 4] = (bcd_q[4*d +: 4] >= 4'd5) ? bcd_q[4*d +: 4] + 4'd3 : bcd_q[4*d +: 4];
    end

    always_comb begin
        cv_d    = cv_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        out_d   = out_q;
        dirty_d = dirty_q;
        case (cv_q)
            CV_IDLE: begin
                if (dirty_q) begin
                    dirty_d = 1'b0;
                    bin_d   = disp_val;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    cv_d    = CV_CONV;
                end
            end
            CV_CONV: begin
                bcd_d = {adj[BW-2:0], bin_q[DATA_W-1]};
                bin_d = bin_q << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    out_d = {adj[BW-2:0], bin_q[DATA_W-1]};
                    cv_d  = CV_DONE;
                end
            end
            default: cv_d = CV_IDLE;
        endcase
        if (dirty_evt) dirty_d = 1'b1;
    end

    assign disp_bcd   = out_q;
    assign busy       = (cv_q != CV_IDLE);
    assign disp_valid = (cv_q == CV_DONE);

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                chst_q[i] <= CH_NORMAL;
                cur_q[i]  <= '0;
                min_q[i]  <= '0;
                max_q[i]  <= '0;
            end
            seen_q  <= '0;
            cv_q    <= CV_IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            out_q   <= '0;
            dirty_q <= 1'b1;
        end else begin
            chst_q  <= chst_d;
            cur_q   <= cur_d;
            min_q   <= min_d;
            max_q   <= max_d;
            seen_q  <= seen_d;
            cv_q    <= cv_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            out_q   <= out_d;
            dirty_q <= dirty_d;
        end
        sel_q  <= disp_sel;
        mode_q <= disp_mode;
    end

endmodule

// File: tb/tb_temp_monitor_n.sv
// Directed bench for temp_monitor_n: flag checks inline, display publications via an expected-value queue.
module tb_temp_monitor_n;

    logic        CLOCK_50 = 1'b0;
    logic        rst;
    logic        sample_valid;
    logic [1:0]  sample_ch;
    logic [7:0]  sample_data;
    logic [7:0]  thresh_hi;
    logic [7:0]  thresh_lo;
    logic [1:0]  disp_sel;
    logic [1:0]  disp_mode;
    logic [3:0]  hot;
    logic [3:0]  cold;
    logic [11:0] disp_bcd;
    logic        busy;
    logic        disp_valid;

    int          total = 0;
    int          bad   = 0;
    logic [11:0] sb [$];
    logic [11:0] exp_bcd;

    always #5 CLOCK_50 = ~CLOCK_50;

    temp_monitor_n #(.CHANNELS(4), .DATA_W(8), .HYST(2), .BCD_DIGITS(3)) dut (
        .CLOCK_50     (CLOCK_50),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample_ch    (sample_ch),
        .sample_data  (sample_data),
        .thresh_hi    (thresh_hi),
        .thresh_lo    (thresh_lo),
        .disp_sel     (disp_sel),
        .disp_mode    (disp_mode),
        .hot          (hot),
        .cold         (cold),
        .disp_bcd     (disp_bcd),
        .busy         (busy),
        .disp_valid   (disp_valid)
    );

    // Every published display value must match the oldest outstanding expectation.
    always @(negedge CLOCK_50) begin
        if (disp_valid === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL disp_unexpected: got %03h want no publication", disp_bcd);
            end else begin
                exp_bcd = sb.pop_front();
                if (disp_bcd !== exp_bcd) begin
                    bad++;
                    $display("FAIL disp_bcd: got %03h want %03h", disp_bcd, exp_bcd);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk_flags(input string name, input logic [3:0] h, input logic [3:0] c);
        chk({name, "_hot"}, {28'd0, hot}, {28'd0, h});
        chk({name, "_cold"}, {28'd0, cold}, {28'd0, c});
    endtask

    task automatic send(input logic [1:0] ch, input logic [7:0] d);
        @(negedge CLOCK_50);
        sample_valid = 1'b1;
        sample_ch    = ch;
        sample_data  = d;
        @(negedge CLOCK_50);
        sample_valid = 1'b0;
    endtask

    task automatic wait_sb(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge CLOCK_50);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got %0d pending want 0", name, sb.size());
            sb.delete();
        end
        repeat (3) @(negedge CLOCK_50);
    endtask

    initial begin
        rst          = 1'b1;
        sample_valid = 1'b0;
        sample_ch    = 2'd0;
        sample_data  = 8'd0;
        thresh_hi    = 8'd100;
        thresh_lo    = 8'd20;
        disp_sel     = 2'd3;
        disp_mode    = 2'b00;
        repeat (3) @(negedge CLOCK_50);

        chk_flags("rst", 4'b0000, 4'b0000);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, disp_valid}, 32'd0);
        chk("rst_bcd", {20'd0, disp_bcd}, 32'd0);

        // Power-up conversion of 0: busy from cycle 1, pulse at cycle 9, idle at cycle 10.
        sb.push_back(12'h000);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLOCK_50);
            chk("pwr_busy", {31'd0, busy}, (k <= 8) ? 32'd1 : 32'd0);
            chk("pwr_valid", {31'd0, disp_valid}, (k == 8) ? 32'd1 : 32'd0);
        end
        wait_sb("pwr");

        send(2'd0, 8'd101); chk_flags("h101", 4'b0001, 4'b0000);
        send(2'd0, 8'd99);  chk_flags("h99",  4'b0001, 4'b0000);
        send(2'd0, 8'd97);  chk_flags("h97",  4'b0000, 4'b0000);

        send(2'd0, 8'd101); chk_flags("c101", 4'b0001, 4'b0000);
        send(2'd0, 8'd15);  chk_flags("c15",  4'b0000, 4'b0001);
        send(2'd0, 8'd22);  chk_flags("c22",  4'b0000, 4'b0001);
        send(2'd0, 8'd23);  chk_flags("c23",  4'b0000, 4'b0000);

        // Saturated exit thresholds: lo+HYST pins at 255, hi-HYST pins at 0.
        thresh_hi = 8'd255; thresh_lo = 8'd254;
        send(2'd2, 8'd10);  chk_flags("sat_lo10",  4'b0000, 4'b0100);
        send(2'd2, 8'd255); chk_flags("sat_lo255", 4'b0000, 4'b0100);
        thresh_hi = 8'd1; thresh_lo = 8'd0;
        send(2'd2, 8'd2);   chk_flags("sat_hi2", 4'b0100, 4'b0000);
        send(2'd2, 8'd0);   chk_flags("sat_hi0", 4'b0100, 4'b0000);
        thresh_hi = 8'd100; thresh_lo = 8'd20;

        send(2'd1, 8'd50);  chk_flags("ch1_50",  4'b0100, 4'b0000);
        send(2'd1, 8'd200); chk_flags("ch1_200", 4'b0110, 4'b0000);
        send(2'd1, 8'd10);  chk_flags("ch1_10",  4'b0100, 4'b0010);

        @(negedge CLOCK_50);
        sb.push_back(12'h200); disp_sel = 2'd1; disp_mode = 2'b10; wait_sb("max");
        sb.push_back(12'h010); disp_mode = 2'b01; wait_sb("min");
        sb.push_back(12'h010); disp_mode = 2'b00; wait_sb("cur");

        sb.push_back(12'h001); disp_mode = 2'b11; wait_sb("pop1");
        sb.push_back(12'h002);
        send(2'd0, 8'd150); chk_flags("pop_150", 4'b0101, 4'b0010);
        wait_sb("pop2");
        send(2'd0, 8'd120); chk_flags("pop_120", 4'b0101, 4'b0010);
        repeat (12) @(negedge CLOCK_50);

        sb.push_back(12'h120); disp_sel = 2'd0; disp_mode = 2'b00; wait_sb("sel0");

        // Second sample lands while the first conversion runs; both publish in order.
        sb.push_back(12'h255);
        sb.push_back(12'h007);
        @(negedge CLOCK_50);
        sample_valid = 1'b1; sample_ch = 2'd0; sample_data = 8'd255;
        @(negedge CLOCK_50);
        sample_valid = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        sample_valid = 1'b1; sample_ch = 2'd0; sample_data = 8'd7;
        @(negedge CLOCK_50);
        sample_valid = 1'b0;
        wait_sb("back2back");

        send(2'd0, 8'd255);
        repeat (3) @(negedge CLOCK_50);
        chk("abort_busy_pre", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge CLOCK_50);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_valid", {31'd0, disp_valid}, 32'd0);
        chk("abort_bcd", {20'd0, disp_bcd}, 32'd0);
        chk_flags("abort", 4'b0000, 4'b0000);
        sb.push_back(12'h000);
        rst = 1'b0;
        wait_sb("abort_pub");
        repeat (15) @(negedge CLOCK_50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
